// File: rtl/tt_sweep_pkg.sv
// Shared types and helpers for the exhaustive truth-table sweep checker.
package tt_sweep_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SWEEP = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_e;

  // Default sizing: IDX_W pattern bits give NPAT patterns per sweep.
  localparam int unsigned N_IN_DEF = 4;
  localparam int unsigned IDX_W    = N_IN_DEF;
  localparam int unsigned NPAT     = 1 << N_IN_DEF;

  // Increment that sticks at max_v instead of wrapping.
  function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic [31:0] max_v);
    return (v >= max_v) ? max_v : v + 32'd1;
  endfunction

endpackage

// File: rtl/tt_sweep_lat_pipe.sv
// Delay line of DEPTH register stages with async clear; DEPTH=0 is a wire.
module lat_pipe #(
  parameter int unsigned DEPTH = 1,
  parameter int unsigned W     = 5
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  generate
    if (DEPTH == 0) begin : g_bypass
      logic unused_clk;
      assign unused_clk = clk ^ rst_n;
      assign q = d;
    end else begin : g_pipe
      logic [W-1:0] stage_q [DEPTH];

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int i = 0; i < int'(DEPTH); i++) stage_q[i] <= '0;
        end else begin
          stage_q[0] <= d;
          for (int i = 1; i < int'(DEPTH); i++) stage_q[i] <= stage_q[i-1];
        end
      end

      assign q = stage_q[DEPTH-1];
    end
  endgenerate

endmodule

// File: rtl/tt_sweep_checker.sv
// Sweeps all 2^N_IN patterns into an external block and checks its delayed
// output against a captured truth table, reporting errors and first failure.
module tt_sweep_checker
  import tt_sweep_pkg::*;
#(
  parameter int unsigned N_IN  = N_IN_DEF,
  parameter int unsigned LAT   = 1,
  parameter int unsigned ERR_W = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic [(1<<N_IN)-1:0]   tt_in,
  output logic [N_IN-1:0]        pat_out,
  output logic                   pat_valid,
  input  logic                   dut_e,
  output logic                   busy,
  output logic                   done,
  output logic                   pass,
  output logic [ERR_W-1:0]       err_cnt,
  output logic [N_IN-1:0]        first_fail,
  output logic                   first_fail_vld
);

  localparam int unsigned N_PAT  = 1 << N_IN;
  localparam int unsigned PIPE_W = N_IN + 1;
  localparam int unsigned CNT_W  = 3;
  localparam logic [N_IN-1:0]  LAST_PAT   = N_IN'(N_PAT - 1);
  localparam logic [CNT_W-1:0] DRAIN_LAST = CNT_W'((LAT > 0) ? LAT - 1 : 0);
  localparam logic [ERR_W-1:0] ERR_MAX    = '1;

  state_e             state_q, state_d;
  logic [N_PAT-1:0]   tt_q, tt_d;
  logic [CNT_W-1:0]   drain_q, drain_d;
  logic [N_IN-1:0]    pat_d;
  logic               pat_valid_d;
  logic [ERR_W-1:0]   err_d;
  logic [N_IN-1:0]    ff_d;
  logic               ffv_d;

  logic [PIPE_W-1:0]  pipe_in, pipe_out;
  logic               cmp_vld;
  logic [N_IN-1:0]    cmp_idx;
  logic               mismatch;

  // Each presented pattern travels alongside the block's latency.
  assign pipe_in = {pat_valid, pat_out};

  lat_pipe #(
    .DEPTH (LAT),
    .W     (PIPE_W)
  ) u_lat_pipe (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (pipe_in),
    .q     (pipe_out)
  );

  assign {cmp_vld, cmp_idx} = pipe_out;
  // Case equality so an unknown block output is never mistaken for a match.
  assign mismatch = (dut_e === tt_q[cmp_idx]) ? 1'b0 : 1'b1;

  always_comb begin
    state_d     = state_q;
    tt_d        = tt_q;
    drain_d     = drain_q;
    pat_d       = pat_out;
    pat_valid_d = 1'b0;
    err_d       = err_cnt;
    ff_d        = first_fail;
    ffv_d       = first_fail_vld;

    if (cmp_vld && mismatch) begin
      err_d = ERR_W'(sat_inc(32'(err_cnt), 32'(ERR_MAX)));
      if (!first_fail_vld) begin
        ff_d  = cmp_idx;
        ffv_d = 1'b1;
      end
    end

    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d     = SWEEP;
          tt_d        = tt_in;
          err_d       = '0;
          ff_d        = '0;
          ffv_d       = 1'b0;
          pat_d       = '0;
          pat_valid_d = 1'b1;
        end
      end
      SWEEP: begin
        if (pat_out == LAST_PAT) begin
          pat_d   = '0;
          drain_d = '0;
          state_d = (LAT > 0) ? DRAIN : DONE;
        end else begin
          pat_d       = pat_out + N_IN'(1);
          pat_valid_d = 1'b1;
        end
      end
      DRAIN: begin
        if (drain_q == DRAIN_LAST) state_d = DONE;
        else                       drain_d = drain_q + CNT_W'(1);
      end
      default: state_d = IDLE;
    endcase
  end

  // State plus registered status outputs derived from the next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      tt_q           <= '0;
      drain_q        <= '0;
      pat_out        <= '0;
      pat_valid      <= 1'b0;
      err_cnt        <= '0;
      first_fail     <= '0;
      first_fail_vld <= 1'b0;
      busy           <= 1'b0;
      done           <= 1'b0;
      pass           <= 1'b0;
    end else begin
      state_q        <= state_d;
      tt_q           <= tt_d;
      drain_q        <= drain_d;
      pat_out        <= pat_d;
      pat_valid      <= pat_valid_d;
      err_cnt        <= err_d;
      first_fail     <= ff_d;
      first_fail_vld <= ffv_d;
      busy           <= (state_d == SWEEP) || (state_d == DRAIN);
      done           <= (state_d == DONE);
      pass           <= (state_d == DONE) && (err_d == '0);
    end
  end

endmodule

// File: tb/tb_tt_sweep_checker.sv
// Scoreboard bench: three checker configurations (LAT 1/0/7) watch modelled
// logic blocks; predicted results are queued at start and popped at done.
module tb_tt_sweep_checker;

  localparam int LAT_A = 1, LAT_B = 0, LAT_C = 7;
  localparam int EMAX_A = 255, EMAX_B = 255, EMAX_C = 7;

  typedef struct {
    int err;
    int ff;
    int ffv;
    int pas;
    int t0;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [15:0] tt_in = '0;

  logic [3:0] po_a, po_b, po_c, ff_a, ff_b, ff_c;
  logic       pv_a, pv_b, pv_c, by_a, by_b, by_c, dn_a, dn_b, dn_c;
  logic       ps_a, ps_b, ps_c, fv_a, fv_b, fv_c;
  logic [7:0] er_a, er_b;
  logic [2:0] er_c;
  logic       e_a, e_b, e_c;

  // Modelled logic block: response table plus per-pattern output delay.
  logic [15:0] m_tt = '0, m_fault = '0, m_resp;
  logic [6:0]  sh_c = '0;
  assign m_resp = m_tt ^ m_fault;
  always @(posedge clk) e_a <= m_resp[po_a];
  assign e_b = m_resp[po_b];
  always @(posedge clk) sh_c <= {sh_c[5:0], m_resp[po_c]};
  assign e_c = sh_c[6];

  tt_sweep_checker #(.N_IN(4), .LAT(LAT_A), .ERR_W(8)) u_a (
    .clk(clk), .rst_n(rst_n), .start(start), .tt_in(tt_in),
    .pat_out(po_a), .pat_valid(pv_a), .dut_e(e_a), .busy(by_a), .done(dn_a),
    .pass(ps_a), .err_cnt(er_a), .first_fail(ff_a), .first_fail_vld(fv_a));

  tt_sweep_checker #(.N_IN(4), .LAT(LAT_B), .ERR_W(8)) u_b (
    .clk(clk), .rst_n(rst_n), .start(start), .tt_in(tt_in),
    .pat_out(po_b), .pat_valid(pv_b), .dut_e(e_b), .busy(by_b), .done(dn_b),
    .pass(ps_b), .err_cnt(er_b), .first_fail(ff_b), .first_fail_vld(fv_b));

  tt_sweep_checker #(.N_IN(4), .LAT(LAT_C), .ERR_W(3)) u_c (
    .clk(clk), .rst_n(rst_n), .start(start), .tt_in(tt_in),
    .pat_out(po_c), .pat_valid(pv_c), .dut_e(e_c), .busy(by_c), .done(dn_c),
    .pass(ps_c), .err_cnt(er_c), .first_fail(ff_c), .first_fail_vld(fv_c));

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int   n_tests = 0, n_fail = 0;
  exp_t q0[$], q1[$], q2[$];
  int   bu[3];
  int   a_t0 = 0;
  bit   a_active = 1'b0;
  logic dp_a = 1'b0, dp_b = 1'b0, dp_c = 1'b0;

  task automatic chk(input string name, input longint act, input longint exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: results follow directly from the block-vs-table difference.
  function automatic exp_t predict(input logic [15:0] diff, input int emax, input int t0);
    exp_t e;
    int cnt = 0;
    e.ff = 0;
    e.ffv = 0;
    for (int i = 0; i < 16; i++) begin
      if (diff[i]) begin
        cnt++;
        if (e.ffv == 0) begin
          e.ff  = i;
          e.ffv = 1;
        end
      end
    end
    e.err = (cnt > emax) ? emax : cnt;
    e.pas = (cnt == 0) ? 1 : 0;
    e.t0  = t0;
    return e;
  endfunction

  task automatic check_done(input int inst, input int err, input int ff, input int ffv,
                            input int pas, input int lat);
    exp_t e;
    int   sz;
    case (inst)
      0:       sz = q0.size();
      1:       sz = q1.size();
      default: sz = q2.size();
    endcase
    if (sz == 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL done_%0d: got unexpected done, expected none pending", inst);
      return;
    end
    case (inst)
      0:       e = q0.pop_front();
      1:       e = q1.pop_front();
      default: e = q2.pop_front();
    endcase
    chk($sformatf("err_cnt_%0d", inst), err, e.err);
    chk($sformatf("first_fail_%0d", inst), ff, e.ff);
    chk($sformatf("first_fail_vld_%0d", inst), ffv, e.ffv);
    chk($sformatf("pass_%0d", inst), pas, e.pas);
    chk($sformatf("done_cycle_%0d", inst), cyc - e.t0, 16 + lat + 1);
  endtask

  // Monitor: results on each done rise, pattern stream of instance A.
  always @(negedge clk) begin
    int k;
    if (rst_n) begin
      if (dn_a && !dp_a) check_done(0, int'(er_a), int'(ff_a), int'(fv_a), int'(ps_a), LAT_A);
      if (dn_b && !dp_b) check_done(1, int'(er_b), int'(ff_b), int'(fv_b), int'(ps_b), LAT_B);
      if (dn_c && !dp_c) check_done(2, int'(er_c), int'(ff_c), int'(fv_c), int'(ps_c), LAT_C);
      if (a_active) begin
        k = cyc - a_t0 - 1;
        chk("pat_valid_a", pv_a, (k >= 0 && k < 16) ? 1 : 0);
        chk("pat_out_a", po_a, (k >= 0 && k < 16) ? k : 0);
        chk("busy_a", by_a, (k >= 0 && k < 16 + LAT_A) ? 1 : 0);
      end
    end
    dp_a = dn_a;
    dp_b = dn_b;
    dp_c = dn_c;
  end

  // Drive start for one cycle; each instance accepts only when not busy.
  task automatic pulse_start(input logic [15:0] tt, input logic [15:0] fault);
    bit acc = 1'b0;
    tt_in = tt;
    start = 1'b1;
    if (cyc > bu[0]) begin
      q0.push_back(predict(fault, EMAX_A, cyc));
      bu[0] = cyc + 16 + LAT_A;
      a_t0 = cyc;
      a_active = 1'b1;
      acc = 1'b1;
    end
    if (cyc > bu[1]) begin
      q1.push_back(predict(fault, EMAX_B, cyc));
      bu[1] = cyc + 16 + LAT_B;
      acc = 1'b1;
    end
    if (cyc > bu[2]) begin
      q2.push_back(predict(fault, EMAX_C, cyc));
      bu[2] = cyc + 16 + LAT_C;
      acc = 1'b1;
    end
    if (acc) begin
      m_tt    = tt;
      m_fault = fault;
    end
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_all();
    for (int i = 0; i < 80 && (q0.size() + q1.size() + q2.size()) != 0; i++) @(negedge clk);
    if ((q0.size() + q1.size() + q2.size()) != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL timeout: got %0d results pending, expected 0", q0.size() + q1.size() + q2.size());
      q0.delete(); q1.delete(); q2.delete();
    end
    @(negedge clk);
  endtask

  task automatic wait_cyc(input int target);
    for (int i = 0; i < 100 && cyc < target; i++) @(negedge clk);
  endtask

  task automatic chk_reset_outputs();
    chk("rst_a", {po_a, pv_a, by_a, dn_a, ps_a, er_a, ff_a, fv_a}, 0);
    chk("rst_b", {po_b, pv_b, by_b, dn_b, ps_b, er_b, ff_b, fv_b}, 0);
    chk("rst_c", {po_c, pv_c, by_c, dn_c, ps_c, er_c, ff_c, fv_c}, 0);
  endtask

  initial begin
    int c0;
    logic [15:0] tt, fl;
    bu = '{0, 0, 0};
    #1 chk_reset_outputs();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Clean block, single faulty pattern, fully inverted block.
    pulse_start(16'hB4E1, 16'h0000);
    wait_all();
    pulse_start(16'hB4E1, 16'h0020);
    wait_all();
    pulse_start(16'hB4E1, 16'hFFFF);
    wait_all();

    // Starts while busy must be ignored even with a different table.
    c0 = cyc;
    pulse_start(16'h5A3C, 16'h0480);
    wait_cyc(c0 + 5);
    pulse_start(16'(~16'h5A3C), 16'hFFFF);
    wait_cyc(c0 + 12);
    pulse_start(16'h0F0F, 16'h0001);
    wait_all();

    // Reset in cycle 9 of a sweep, then a clean run.
    c0 = cyc;
    pulse_start(16'h1234, 16'h0300);
    wait_cyc(c0 + 9);
    #2 rst_n = 1'b0;
    #1 chk_reset_outputs();
    q0.delete(); q1.delete(); q2.delete();
    bu = '{0, 0, 0};
    a_active = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    pulse_start(16'hB4E1, 16'h8000);
    wait_all();

    // Randomised runs, each restarted from DONE.
    for (int r = 0; r < 20; r++) begin
      tt = 16'($urandom);
      case ($urandom_range(0, 3))
        0:       fl = 16'h0000;
        1:       fl = 16'($urandom) & 16'($urandom) & 16'($urandom);
        2:       fl = 16'(1 << $urandom_range(0, 15));
        default: fl = 16'($urandom);
      endcase
      pulse_start(tt, fl);
      wait_all();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
